// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: segment bit order, active-low hex glyphs,
// the blank glyph, and small helpers used by the segment readers/decoders.
package seg7_pkg;

  // Bit position of each segment on an active-low segment bus.
  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_bit_e;

  localparam int SEG_W = 7;

  // All segments off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs for hex digits 0..F, indexed by value.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reader settle/lock state.
  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_LOCKED = 1'b1
  } rd_state_e;

  // Saturating increment for the 4-bit stability counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'h1;
  endfunction

endpackage

// File: rtl/seg7_pattern_lut.sv
// Combinational lookup of an active-low segment pattern to its hex code,
// with blank and not-in-table indications.
module seg7_pattern_lut
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] code,
  output logic       blank,
  output logic       err
);

  // Search the glyph table; anything unmatched and not blank is an error.
  always_comb begin
    code  = 4'h0;
    blank = 1'b0;
    err   = 1'b1;
    if (seg_n == SEG_BLANK) begin
      blank = 1'b1;
      err   = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        code = (seg_n == SEG_HEX[i]) ? 4'(i) : code;
        err  = (seg_n == SEG_HEX[i]) ? 1'b0  : err;
      end
    end
  end

endmodule

// File: rtl/seg7_reader.sv
// Reads a multiplexed seven-segment display: waits for the segment bus and
// digit strobe to hold still for STABLE_CNT samples, decodes the glyph once
// per stable window and offers it on a valid/ready output with a sticky
// overflow flag for captures that had nowhere to go.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CNT = 4,
  parameter int DIGITS     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_n,
  input  logic [DIGITS-1:0] dig_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_code,
  output logic [1:0]        out_digit,
  output logic              out_blank,
  output logic              out_err,
  output logic              overflow
);

  localparam int         SW       = SEG_W + DIGITS;
  localparam logic [3:0] CNT_LAST = 4'(STABLE_CNT - 1);

  logic [SW-1:0] smp_q;
  logic [SW-1:0] smp_d;
  rd_state_e     state_q;
  logic [3:0]    cnt_q;

  logic          same_s;
  logic          onehot_s;
  logic [1:0]    idx_s;
  logic          capture_s;
  logic [3:0]    lut_code_s;
  logic          lut_blank_s;
  logic          lut_err_s;

  logic          valid_q;
  logic [3:0]    code_q;
  logic [1:0]    digit_q;
  logic          blank_q;
  logic          err_q;
  logic          ovf_q;

  assign smp_d    = {seg_n, dig_sel};
  assign same_s   = (smp_d == smp_q);
  assign onehot_s = $onehot(smp_q[DIGITS-1:0]);

  // Capture only on the sample that completes a window, and only for a
  // single strobed digit; a bad strobe still locks so it is not retried.
  assign capture_s = (state_q == ST_SETTLE) && same_s &&
                     (cnt_q == CNT_LAST) && onehot_s;

  // Index of the strobed digit in the held sample.
  always_comb begin
    idx_s = 2'd0;
    for (int i = 0; i < DIGITS; i++) begin
      idx_s = smp_q[i] ? 2'(i) : idx_s;
    end
  end

  seg7_pattern_lut u_lut (
    .seg_n (smp_q[DIGITS + int'(SEG_A) +: SEG_W]),
    .code  (lut_code_s),
    .blank (lut_blank_s),
    .err   (lut_err_s)
  );

  // Sample register, stability counter and settle/lock state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q   <= {SEG_BLANK, {DIGITS{1'b0}}};
      cnt_q   <= 4'h0;
      state_q <= ST_SETTLE;
    end else begin
      smp_q <= smp_d;
      case (state_q)
        ST_SETTLE: begin
          if (!same_s) begin
            cnt_q <= 4'h0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= sat_inc4(cnt_q);
            state_q <= ST_LOCKED;
          end else begin
            cnt_q <= sat_inc4(cnt_q);
          end
        end
        ST_LOCKED: begin
          if (same_s) begin
            cnt_q <= sat_inc4(cnt_q);
          end else begin
            cnt_q   <= 4'h0;
            state_q <= ST_SETTLE;
          end
        end
        default: begin
          cnt_q   <= 4'h0;
          state_q <= ST_SETTLE;
        end
      endcase
    end
  end

  // Output holding register: load on capture when free or being drained,
  // otherwise flag the drop; clear valid on a completed handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      code_q  <= 4'h0;
      digit_q <= 2'd0;
      blank_q <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (capture_s && (!valid_q || out_ready)) begin
      valid_q <= 1'b1;
      code_q  <= lut_code_s;
      digit_q <= idx_s;
      blank_q <= lut_blank_s;
      err_q   <= lut_err_s;
    end else if (capture_s) begin
      ovf_q <= 1'b1;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign out_valid = valid_q;
  assign out_code  = code_q;
  assign out_digit = digit_q;
  assign out_blank = blank_q;
  assign out_err   = err_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: directed scenarios plus randomized
// windows, compared every cycle against a run-length reference model.
module tb_seg7_reader;

  localparam int SC = 4;
  localparam int DG = 4;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic [6:0]    seg_n     = 7'h7F;
  logic [DG-1:0] dig_sel   = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [3:0]    out_code;
  logic [1:0]    out_digit;
  logic          out_blank;
  logic          out_err;
  logic          overflow;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model state
  logic [6:0]    hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0]    m_prev_seg;
  logic [DG-1:0] m_prev_dig;
  int            m_run;
  logic          m_valid;
  logic [3:0]    m_code;
  logic [1:0]    m_digit;
  logic          m_blank;
  logic          m_err;
  logic          m_ovf;

  seg7_reader #(.STABLE_CNT(SC), .DIGITS(DG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_n     (seg_n),
    .dig_sel   (dig_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_digit (out_digit),
    .out_blank (out_blank),
    .out_err   (out_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_prev_seg = 7'h7F;
    m_prev_dig = '0;
    m_run      = 0;
    m_valid    = 1'b0;
    m_code     = 4'h0;
    m_digit    = 2'd0;
    m_blank    = 1'b0;
    m_err      = 1'b0;
    m_ovf      = 1'b0;
  endfunction

  // One clock edge of the reference: a capture happens when the input has
  // repeated exactly SC times in a row and exactly one digit is strobed.
  function automatic void model_edge(input logic [6:0] s, input logic [DG-1:0] d, input logic rdy);
    logic       cap;
    logic [3:0] c;
    logic       b;
    logic       e;
    int         idx;
    if (s == m_prev_seg && d == m_prev_dig) m_run++;
    else m_run = 0;
    m_prev_seg = s;
    m_prev_dig = d;
    cap = (m_run == SC) && ($countones(d) == 1);
    c = 4'h0; b = 1'b0; e = 1'b1;
    if (s == 7'h7F) begin b = 1'b1; e = 1'b0; end
    for (int i = 0; i < 16; i++) if (s == hex_tab[i]) begin c = 4'(i); e = 1'b0; end
    idx = 0;
    for (int i = 0; i < DG; i++) if (d[i]) idx = i;
    if (cap && (!m_valid || rdy)) begin
      m_valid = 1'b1; m_code = c; m_digit = 2'(idx); m_blank = b; m_err = e;
    end else if (cap) begin
      m_ovf = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "/valid"},    32'(out_valid), 32'(m_valid));
    chk({tag, "/code"},     32'(out_code),  32'(m_code));
    chk({tag, "/digit"},    32'(out_digit), 32'(m_digit));
    chk({tag, "/blank"},    32'(out_blank), 32'(m_blank));
    chk({tag, "/err"},      32'(out_err),   32'(m_err));
    chk({tag, "/overflow"}, 32'(overflow),  32'(m_ovf));
  endtask

  task automatic step(input string tag, input logic [6:0] s, input logic [DG-1:0] d, input logic rdy);
    seg_n = s; dig_sel = d; out_ready = rdy;
    @(posedge clk);
    model_edge(s, d, rdy);
    #1;
    check_all(tag);
  endtask

  // Assert reset away from the clock edge, check outputs clear at once.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic seen;
    logic [6:0] rs;
    logic [DG-1:0] rd;
    int hold;

    model_reset();
    #1;
    check_all("reset_hold");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Stable '2' on digit 2: valid after SC edges past the first sample.
    for (int i = 0; i < 4; i++) step("hold24", 7'h24, 4'b0100, 1'b0);
    chk("hold24_not_yet", 32'(out_valid), 32'd0);
    step("hold24", 7'h24, 4'b0100, 1'b0);
    chk("hold24_valid", 32'(out_valid), 32'd1);
    chk("hold24_code",  32'(out_code),  32'd2);
    chk("hold24_digit", 32'(out_digit), 32'd2);
    step("hold24", 7'h24, 4'b0100, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step("hold24_once", 7'h24, 4'b0100, 1'b1);
      seen |= out_valid;
    end
    chk("hold24_single_capture", 32'(seen), 32'd0);

    // Toggling pattern never settles.
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step("toggle", (i % 4 < 2) ? 7'h40 : 7'h79, 4'b0001, 1'b1);
      seen |= out_valid;
    end
    chk("toggle_never_valid", 32'(seen), 32'd0);

    // Blocked consumer: second window dropped, overflow set.
    for (int i = 0; i < 6; i++) step("ovf_F", 7'h0E, 4'b0001, 1'b0);
    for (int i = 0; i < 6; i++) step("ovf_blank", 7'h7F, 4'b0001, 1'b0);
    chk("ovf_code",  32'(out_code),  32'd15);
    chk("ovf_blank", 32'(out_blank), 32'd0);
    chk("ovf_flag",  32'(overflow),  32'd1);

    // Capture coinciding with a handshake on held data.
    do_reset("rst_a");
    for (int i = 0; i < 6; i++) step("hs_A", 7'h19, 4'b0010, 1'b0);
    for (int i = 0; i < 4; i++) step("hs_B", 7'h46, 4'b1000, 1'b0);
    step("hs_B_cap", 7'h46, 4'b1000, 1'b1);
    chk("hs_valid", 32'(out_valid), 32'd1);
    chk("hs_code",  32'(out_code),  32'd12);
    chk("hs_digit", 32'(out_digit), 32'd3);
    chk("hs_ovf",   32'(overflow),  32'd0);
    step("hs_drain", 7'h46, 4'b1000, 1'b1);

    // Unknown pattern and bad strobes.
    for (int i = 0; i < 6; i++) step("err55", 7'h55, 4'b0001, 1'b0);
    chk("err55_err",  32'(out_err),  32'd1);
    chk("err55_code", 32'(out_code), 32'd0);
    step("err55_drain", 7'h55, 4'b0001, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin step("dig0000", 7'h24, 4'b0000, 1'b1); seen |= out_valid; end
    for (int i = 0; i < 7; i++) begin step("dig0011", 7'h24, 4'b0011, 1'b1); seen |= out_valid; end
    chk("bad_strobe_no_capture", 32'(seen), 32'd0);

    // Reset mid-window, then a full new window is needed.
    for (int i = 0; i < 3; i++) step("mid_win", 7'h30, 4'b0001, 1'b0);
    do_reset("rst_mid");
    for (int i = 0; i < 4; i++) step("post_rst", 7'h30, 4'b0001, 1'b0);
    chk("post_rst_not_yet", 32'(out_valid), 32'd0);
    step("post_rst", 7'h30, 4'b0001, 1'b0);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_code",  32'(out_code),  32'd3);

    // Randomized windows of varying length, strobe and readiness.
    do_reset("rst_rand");
    for (int w = 0; w < 60; w++) begin
      case ($urandom_range(0, 3))
        0:       rs = 7'h7F;
        1:       rs = 7'($urandom);
        default: rs = hex_tab[$urandom_range(0, 15)];
      endcase
      rd = ($urandom_range(0, 3) != 0) ? DG'(1 << $urandom_range(0, DG - 1)) : DG'($urandom);
      hold = $urandom_range(1, 8);
      for (int k = 0; k < hold; k++) step("rand", rs, rd, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 4, meaning the consecutive identical samples required before capture (legal range 2..15).
REQ-002 SHALL have parameter DIGITS, default 4, meaning the number of multiplexed digit strobes.
REQ-003 SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, width 1: reset, asynchronous and active-low.
REQ-005 SHALL have port seg_n, input, width 7: active-low segment bus, bit0=a through bit6=g.
REQ-006 SHALL have port dig_sel, input, width DIGITS: active-high one-hot digit strobe.
REQ-007 SHALL have port out_valid, output, width 1: the capture register holds data.
REQ-008 SHALL have port out_ready, input, width 1: the consumer accepts data.
REQ-009 SHALL have port out_code, output, width 4: the decoded hex value.
REQ-010 SHALL have port out_digit, output, width 2: the index of the strobed digit.
REQ-011 SHALL have port out_blank, output, width 1: the pattern was all segments off.
REQ-012 SHALL have port out_err, output, width 1: the pattern is not in the decode table.
REQ-013 SHALL have port overflow, output, width 1: sticky flag, set when a capture is dropped.

Function
REQ-014 SHALL register {seg_n, dig_sel} each cycle into a sample register and compare each new sample with the previous one.
REQ-015 SHALL run a two-state FSM:
- SETTLE: the stability counter increments on an equal sample and clears to 0 on a differing sample.
- SETTLE -> LOCKED when the counter reaches STABLE_CNT-1 with an equal sample; this edge is the capture event.
- LOCKED -> SETTLE on any differing sample, with the counter cleared.
REQ-016 SHALL issue exactly one capture event per stable window, and none while in LOCKED.
REQ-017 SHALL suppress the capture event, and leave overflow unchanged, when dig_sel is zero or multi-hot; the FSM still enters LOCKED.
REQ-018 SHALL decode active-low patterns, listed as hex seg_n values for 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
REQ-019 SHALL decode 7F as out_blank=1, out_code=0, out_err=0.
REQ-020 SHALL decode any other pattern as out_err=1, out_code=0, out_blank=0.
REQ-021 SHALL, for inputs held constant from sample edge t, assert out_valid after edge t+STABLE_CNT, with outputs registered (no combinational path from inputs).
REQ-022 SHALL keep out_valid high, with out_code, out_digit, out_blank and out_err stable, until a cycle where out_valid && out_ready.
REQ-023 SHALL, on a capture while out_valid && !out_ready, drop the new data, keep the old data, and set overflow.
REQ-024 SHALL, on a capture in the same cycle as a completed handshake, load the new data and keep out_valid at 1 without overflow.
REQ-025 SHALL saturate the stability counter and never wrap it.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force the FSM to SETTLE and clear the counter and sample register (seg_n sample to 7F, dig_sel sample to 0).
REQ-027 SHALL, while rst_n=0, force out_valid, out_code, out_digit, out_blank, out_err and overflow to 0.
REQ-028 SHALL, on rst_n asserted mid-window or mid-handshake, discard pending data, and require a full new stable window after release.

Structure
REQ-029 SHALL keep the 16 hex patterns, the blank pattern (7F) and the segment bit-order constants in the shared seg7 constants file, reused by the display decoders.
REQ-030 SHALL place the pattern-to-code lookup in one combinational sub-module, seg7_pattern_lut, with inputs seg_n and outputs code, blank and err.

Verification
REQ-031 SHALL cover this scenario: seg_n=24, dig_sel=0100 held 6 cycles -> out_valid rises after the 4th sample edge with out_code=2, out_digit=2, and one capture only.
REQ-032 SHALL cover this scenario: seg_n toggling 40/79 every 2 cycles -> out_valid never asserts.
REQ-033 SHALL cover this scenario: out_ready=0 and two stable windows (0E, then 7F) -> first capture held (code F), overflow=1, blank not visible.
REQ-034 SHALL cover this scenario: capture coinciding with out_ready=1 on held data -> new data loaded, out_valid stays 1, overflow stays 0.
REQ-035 SHALL cover this scenario: seg_n=55 stable on digit 0 -> out_err=1, out_code=0; dig_sel=0000 or 0011 stable -> no capture.
REQ-036 SHALL cover this scenario: rst_n pulsed low at count 2 -> all outputs 0 immediately; after release a capture needs STABLE_CNT new equal samples.
